// File: rtl/axi_burst_ram_slave_if.sv
// ----------------------------------------------------------------------------
// axi_burst_ram_slave_if
// Purpose : AXI4 (full) bus bundle between a burst master (e.g. the DMA data
//           port) and the RAM-backed slave. Clock and reset stay outside the
//           interface as plain ports of the connected modules.
// Signals : AW channel  awready, awvalid, awaddr, awid, awlen, awsize, awburst
//           W  channel  wready, wvalid, wdata, wstrb, wlast
//           B  channel  bready, bvalid, bid, bresp
//           AR channel  arready, arvalid, araddr, arid, arlen, arsize, arburst
//           R  channel  rready, rvalid, rdata, rid, rresp, rlast
// Modports: slave  - the responder (drives readies on AW/W/AR and B/R payload)
//           master - the initiator (drives valids and request payload)
// ----------------------------------------------------------------------------
interface axi_burst_ram_slave_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int BUS_WIDTH  = 32,
   parameter int ID_WIDTH   = 1
);
   localparam int BYTES = BUS_WIDTH / 8;

   // write address channel
   logic                  awready;
   logic                  awvalid;
   logic [ADDR_WIDTH-1:0] awaddr;
   logic [ID_WIDTH-1:0]   awid;
   logic [7:0]            awlen;
   logic [2:0]            awsize;
   logic [1:0]            awburst;

   // write data channel
   logic                  wready;
   logic                  wvalid;
   logic [BUS_WIDTH-1:0]  wdata;
   logic [BYTES-1:0]      wstrb;
   logic                  wlast;

   // write response channel
   logic                  bready;
   logic                  bvalid;
   logic [ID_WIDTH-1:0]   bid;
   logic [1:0]            bresp;

   // read address channel
   logic                  arready;
   logic                  arvalid;
   logic [ADDR_WIDTH-1:0] araddr;
   logic [ID_WIDTH-1:0]   arid;
   logic [7:0]            arlen;
   logic [2:0]            arsize;
   logic [1:0]            arburst;

   // read data channel
   logic                  rready;
   logic                  rvalid;
   logic [BUS_WIDTH-1:0]  rdata;
   logic [ID_WIDTH-1:0]   rid;
   logic [1:0]            rresp;
   logic                  rlast;

   modport slave (
      output awready,
      input  awvalid, awaddr, awid, awlen, awsize, awburst,
      output wready,
      input  wvalid, wdata, wstrb, wlast,
      input  bready,
      output bvalid, bid, bresp,
      output arready,
      input  arvalid, araddr, arid, arlen, arsize, arburst,
      input  rready,
      output rvalid, rdata, rid, rresp, rlast
   );

   modport master (
      input  awready,
      output awvalid, awaddr, awid, awlen, awsize, awburst,
      input  wready,
      output wvalid, wdata, wstrb, wlast,
      output bready,
      input  bvalid, bid, bresp,
      input  arready,
      output arvalid, araddr, arid, arlen, arsize, arburst,
      output rready,
      input  rvalid, rdata, rid, rresp, rlast
   );
endinterface

// File: rtl/axi_burst_ram_slave.sv
// ----------------------------------------------------------------------------
// axi_burst_ram_slave
// Purpose : AXI4 (full) slave backed by a word-addressed RAM, used as the DMA
//           source/destination memory. Independent read and write engines
//           serve FIXED, INCR and WRAP bursts of up to 256 beats.
// Ports   : clk     - clock, all logic on the rising edge
//           reset_n - asynchronous active-low reset (aborts open bursts)
//           s_axi   - axi_burst_ram_slave_if.slave bundle (AW/W/B/AR/R)
// Notes   : Illegal bursts (size wider than the bus, reserved burst type,
//           WRAP length not 2/4/8/16) answer SLVERR on every beat and never
//           touch the RAM. Beats addressed past the end of the RAM answer
//           DECERR. bresp reports the worst beat (DECERR > SLVERR > OKAY).
// ----------------------------------------------------------------------------
module axi_burst_ram_slave #(
   parameter int ADDR_WIDTH = 32,
   parameter int BUS_WIDTH  = 32,
   parameter int ID_WIDTH   = 1,
   parameter int MEM_WORDS  = 4096
) (
   input  logic                   clk,
   input  logic                   reset_n,
   axi_burst_ram_slave_if.slave   s_axi
);

   localparam int BYTES = BUS_WIDTH / 8;
   localparam int LSB   = $clog2(BYTES);
   localparam int IDX_W = $clog2(MEM_WORDS);
   localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH + 1)'(MEM_WORDS * BYTES);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

   // A burst is rejected as a whole when it cannot be served by this bus.
   function automatic logic burst_illegal(input logic [2:0] size, input logic [7:0] len,
                                          input logic [1:0] burst);
      logic bad_wrap_len;
      bad_wrap_len = !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
      return (int'(size) > LSB) || (burst == 2'b11) || (burst == 2'b10 && bad_wrap_len);
   endfunction

   // WRAP keeps the bits above the window from the current address and lets
   // only the in-window bits roll over, which lands on the window base.
   function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                       input logic [2:0] size,
                                                       input logic [7:0] len,
                                                       input logic [1:0] burst);
      logic [ADDR_WIDTH-1:0] inc;
      logic [ADDR_WIDTH-1:0] mask;
      inc  = ADDR_WIDTH'(1) << size;
      mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
      case (burst)
         2'b00:   return addr;
         2'b10:   return (addr & ~mask) | ((addr + inc) & mask);
         default: return addr + inc;
      endcase
   endfunction

   logic [BUS_WIDTH-1:0] mem [MEM_WORDS];

   // ---------------------------------------------------------------- write side
   w_state_t              w_state;
   w_state_t              w_next;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic [ID_WIDTH-1:0]   w_id;
   logic [7:0]            w_len;
   logic [7:0]            w_cnt;
   logic [2:0]            w_size;
   logic [1:0]            w_burst;
   logic                  w_bad;
   logic [1:0]            w_resp;
   logic                  aw_fire;
   logic                  w_fire;
   logic                  w_oob;
   logic                  w_beat_ok;
   logic [1:0]            w_beat_resp;
   logic [IDX_W-1:0]      w_idx;

   // Write engine state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         w_state <= W_IDLE;
      end else begin
         w_state <= w_next;
      end
   end

   // Write engine sequencing: AW is only taken when no burst is open, so a new
   // address waits until the B handshake of the previous burst has completed.
   always_comb begin
      w_next        = w_state;
      s_axi.awready = 1'b0;
      s_axi.wready  = 1'b0;
      s_axi.bvalid  = 1'b0;
      case (w_state)
         W_IDLE: begin
            s_axi.awready = 1'b1;
            if (s_axi.awvalid) w_next = W_DATA;
         end
         W_DATA: begin
            s_axi.wready = 1'b1;
            if (s_axi.wvalid && w_cnt == 8'd0) w_next = W_RESP;
         end
         W_RESP: begin
            s_axi.bvalid = 1'b1;
            if (s_axi.bready) w_next = W_IDLE;
         end
         default: w_next = W_IDLE;
      endcase
   end

   // Per-beat classification. A wlast in the wrong place only downgrades the
   // response; the beat is still written and the counter alone ends the burst.
   always_comb begin
      aw_fire     = (w_state == W_IDLE) && s_axi.awvalid;
      w_fire      = (w_state == W_DATA) && s_axi.wvalid;
      w_oob       = {1'b0, w_addr} >= MEM_BYTES;
      w_beat_ok   = !w_bad && !w_oob;
      w_idx       = w_addr[LSB +: IDX_W];
      w_beat_resp = RESP_OKAY;
      if (w_bad) begin
         w_beat_resp = RESP_SLVERR;
      end else if (w_oob) begin
         w_beat_resp = RESP_DECERR;
      end
      if ((s_axi.wlast != (w_cnt == 8'd0)) && w_beat_resp == RESP_OKAY) begin
         w_beat_resp = RESP_SLVERR;
      end
   end

   // Write burst context: latched on AW, stepped on every W beat. The response
   // code is encoded so that a plain numeric maximum gives the worst case.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         w_addr  <= '0;
         w_id    <= '0;
         w_len   <= '0;
         w_cnt   <= '0;
         w_size  <= '0;
         w_burst <= '0;
         w_bad   <= 1'b0;
         w_resp  <= RESP_OKAY;
      end else if (aw_fire) begin
         w_addr  <= s_axi.awaddr;
         w_id    <= s_axi.awid;
         w_len   <= s_axi.awlen;
         w_cnt   <= s_axi.awlen;
         w_size  <= s_axi.awsize;
         w_burst <= s_axi.awburst;
         w_bad   <= burst_illegal(s_axi.awsize, s_axi.awlen, s_axi.awburst);
         w_resp  <= RESP_OKAY;
      end else if (w_fire) begin
         w_addr <= next_addr(w_addr, w_size, w_len, w_burst);
         w_cnt  <= w_cnt - 8'd1;
         if (w_beat_resp > w_resp) w_resp <= w_beat_resp;
      end
   end

   assign s_axi.bresp = w_resp;
   assign s_axi.bid   = w_id;

   // RAM write port; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (w_fire && w_beat_ok) begin
         for (int i = 0; i < BYTES; i++) begin
            if (s_axi.wstrb[i]) mem[w_idx][i*8 +: 8] <= s_axi.wdata[i*8 +: 8];
         end
      end
   end

   // ----------------------------------------------------------------- read side
   r_state_t              r_state;
   r_state_t              r_next;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [ID_WIDTH-1:0]   r_id;
   logic [7:0]            r_len;
   logic [7:0]            r_cnt;
   logic [2:0]            r_size;
   logic [1:0]            r_burst;
   logic                  r_bad;
   logic [BUS_WIDTH-1:0]  rdata_q;
   logic [1:0]            rresp_q;
   logic                  rlast_q;
   logic                  ar_fire;
   logic                  r_fire;
   logic                  ar_bad;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic                  rd_bad;
   logic                  rd_oob;
   logic [BUS_WIDTH-1:0]  rd_data;
   logic [1:0]            rd_resp;

   // Read engine state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= R_IDLE;
      end else begin
         r_state <= r_next;
      end
   end

   // Read engine sequencing: rvalid follows the state, so the first beat is
   // presented the cycle after the AR handshake.
   always_comb begin
      r_next        = r_state;
      s_axi.arready = 1'b0;
      s_axi.rvalid  = 1'b0;
      case (r_state)
         R_IDLE: begin
            s_axi.arready = 1'b1;
            if (s_axi.arvalid) r_next = R_DATA;
         end
         R_DATA: begin
            s_axi.rvalid = 1'b1;
            if (s_axi.rready && rlast_q) r_next = R_IDLE;
         end
         default: r_next = R_IDLE;
      endcase
   end

   // The beat being fetched comes from the AR bus for beat 0 and from the
   // running burst address afterwards; error beats return zero data.
   always_comb begin
      ar_fire = (r_state == R_IDLE) && s_axi.arvalid;
      r_fire  = (r_state == R_DATA) && s_axi.rready;
      ar_bad  = burst_illegal(s_axi.arsize, s_axi.arlen, s_axi.arburst);
      rd_addr = (r_state == R_IDLE) ? s_axi.araddr : r_addr;
      rd_bad  = (r_state == R_IDLE) ? ar_bad : r_bad;
      rd_oob  = {1'b0, rd_addr} >= MEM_BYTES;
      rd_data = '0;
      rd_resp = RESP_OKAY;
      if (rd_bad) begin
         rd_resp = RESP_SLVERR;
      end else if (rd_oob) begin
         rd_resp = RESP_DECERR;
      end else begin
         rd_data = mem[rd_addr[LSB +: IDX_W]];
      end
   end

   // Read burst context and the registered R payload. r_cnt counts the beats
   // still to come after the one currently presented.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_addr  <= '0;
         r_id    <= '0;
         r_len   <= '0;
         r_cnt   <= '0;
         r_size  <= '0;
         r_burst <= '0;
         r_bad   <= 1'b0;
         rdata_q <= '0;
         rresp_q <= RESP_OKAY;
         rlast_q <= 1'b0;
      end else if (ar_fire) begin
         r_addr  <= next_addr(s_axi.araddr, s_axi.arsize, s_axi.arlen, s_axi.arburst);
         r_id    <= s_axi.arid;
         r_len   <= s_axi.arlen;
         r_cnt   <= s_axi.arlen;
         r_size  <= s_axi.arsize;
         r_burst <= s_axi.arburst;
         r_bad   <= ar_bad;
         rdata_q <= rd_data;
         rresp_q <= rd_resp;
         rlast_q <= (s_axi.arlen == 8'd0);
      end else if (r_fire) begin
         if (rlast_q) begin
            rlast_q <= 1'b0;
         end else begin
            r_addr  <= next_addr(r_addr, r_size, r_len, r_burst);
            r_cnt   <= r_cnt - 8'd1;
            rdata_q <= rd_data;
            rresp_q <= rd_resp;
            rlast_q <= (r_cnt == 8'd1);
         end
      end
   end

   assign s_axi.rdata = rdata_q;
   assign s_axi.rresp = rresp_q;
   assign s_axi.rlast = rlast_q;
   assign s_axi.rid   = r_id;

endmodule
